// File: rtl/cache_arbiter.sv
// Arbitrates the I-cache and D-cache miss paths onto one cacheline adaptor port.
// Contention alternates priority; each request is latched and served to completion.
module cache_arbiter #(
  parameter int unsigned LINE_WIDTH = 256,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} state_t;
  typedef enum logic {GRANT_I, GRANT_D} side_t;

  state_t state;
  side_t  last_grant;
  logic   d_req;
  logic   pick_d;

  assign d_req  = d_read | d_write;
  // Under contention the side that was not served last wins.
  assign pick_d = d_req & (~i_read | (last_grant == GRANT_I));

  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;
  assign i_resp  = mem_resp & (state == SERVE_I);
  assign d_resp  = mem_resp & (state == SERVE_D);

  // The mem_* registers double as the holding registers, so the adaptor
  // only ever sees values captured on the grant edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      last_grant  <= GRANT_I;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_d) begin
            state       <= SERVE_D;
            last_grant  <= GRANT_D;
            mem_address <= d_address;
            mem_wdata   <= d_wdata;
            mem_write   <= d_write;
            mem_read    <= ~d_write;
          end else if (i_read) begin
            state       <= SERVE_I;
            last_grant  <= GRANT_I;
            mem_address <= i_address;
            mem_wdata   <= '0;
            mem_write   <= 1'b0;
            mem_read    <= 1'b1;
          end
        end
        SERVE_I, SERVE_D: begin
          if (mem_resp) begin
            state       <= RELEASE;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
